sqrt_datapath: RTL and testbench
================================

# sqrt_datapath

Datapath companion to the square-root ControlPath. It holds the operand, the running odd-number sum and the increment, and computes with a single shared adder. It returns the status pair `N` that the controller branches on and publishes the integer square root when the controller commands a capture. It consumes `boot`/`muxes`/`wr_root`/`wr_square`/`root` directly from the ControlPath outputs and drives the ControlPath `N_i` input.

## Interface
- WIDTH, 16, operand width; must be even; root width is WIDTH/2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- x_i  in  WIDTH  operand; sampled only on boot cycles
- start_i  in  1  external start request; forwarded on N_o[1]
- boot_i  in  1  load initial values (priority over all other writes)
- muxes_i  in  1  adder operand select: 0 → D+2, 1 → S+D
- wr_root_i  in  1  write D ← adder
- wr_square_i  in  1  write S ← adder
- root_i  in  1  capture result: R ← D>>1, set valid
- N_o  out  2  status to ControlPath: N_o[1]=start_i, N_o[0]=(S > X)
- root_o  out  WIDTH/2  captured root R
- valid_o  out  1  R holds the root of the current X

## Operation
- Internal registers:
  - X: WIDTH bits.
  - S (square): WIDTH+1 bits.
  - D (increment): WIDTH/2+2 bits.
  - R: WIDTH/2 bits.
  - V (valid): 1 bit.
- Algorithm: S=1, D=1; while S ≤ X { D+=2; S+=D }; root = D>>1.
- Adder: one (WIDTH+1)-bit adder.
  - muxes_i=0: A=D zero-extended, B=2.
  - muxes_i=1: A=S, B=D zero-extended.
  - Sum wraps modulo 2^(WIDTH+1). A legal control sequence never wraps, because max S = 2^WIDTH for X = 2^WIDTH−1.
- Write priority per rising edge, with rst=0:
  1. boot_i=1: X←x_i, S←1, D←1, V←0, R unchanged. wr_root_i, wr_square_i and root_i are ignored.
  2. Else, independently:
     - wr_root_i=1: D ← sum truncated to D width.
     - wr_square_i=1: S ← sum.
     - Both asserted: both registers take the same sum.
  3. root_i=1 with boot_i=0: R←D[WIDTH/2:1], V←1. If D is written in the same cycle, the capture uses the pre-edge D.
- N_o[0] is combinational: unsigned compare of S against X zero-extended to WIDTH+1 bits.
- N_o[1] is a combinational pass-through of start_i. It is not registered; the ControlPath registers it.
- valid_o=V. It stays 1 until the next boot cycle, and R stays stable while V=1.
- No internal FSM sequencing. All sequencing is owned by the ControlPath. The datapath only guarantees register semantics and the flags.

## Timing
- Reset values: X=0, S=1, D=1, R=0, V=0.
  - Resulting outputs: N_o[0]=1 (1>0), N_o[1]=start_i, root_o=0, valid_o=0.
- rst applied mid-computation returns all registers to these reset values at the next edge. The partial result is discarded.
- Latency, with the ControlPath running boot → (D+=2, S+=D, check) × root → capture:
  - Every register write is visible the cycle after the edge.
  - N_o[0] reflects S after the wr_square edge, with zero combinational delay in cycles.
- Boot asserted during iteration restarts with the new x_i. V is forced to 0 at that edge.
- X is not re-sampled outside boot_i. Changing x_i mid-computation has no effect.
- Worst case iterations = 2^(WIDTH/2) − 1 (255 for WIDTH=16).

## Test plan
- Reset: hold rst=1 for 2 edges with random control inputs.
  - Required: root_o=0, valid_o=0, N_o[0]=1. start_i toggling is seen on N_o[1] in the same cycle.
- x=0: boot, then root_i with no iterations.
  - Required: N_o[0]=1 right after boot, root_o=0, valid_o=1.
- x=16: boot, then iterate D+=2 / S+=D until N_o[0]=1, then capture.
  - Required: S sequence 1,4,9,16,25 and D sequence 1,3,5,7,9.
  - Required: N_o[0] rises only after S=25; root_o=4.
- x=65535 (max): full iteration.
  - Required: final S=65536 (bit WIDTH set, no wrap), D=511, root_o=255.
  - Required: N_o[0]=0 at S=65025.
- Priority: assert boot_i together with wr_root_i, wr_square_i and root_i, with x_i=9.
  - Required: S=1, D=1, X=9, valid_o=0, root_o keeps its previous value.
- Mid-operation disturbance:
  - Change x_i after boot: the result stays the root of the booted X.
  - Assert rst halfway through x=100: registers return to reset values.
  - A re-run of x=100 gives root_o=10.

Source files
------------

// File: rtl/sqrt_datapath.sv
// Square-root datapath: operand, odd-number running sum and increment sharing one adder.
// Returns the (start, S>X) status pair to the ControlPath and captures the root on command.
module sqrt_datapath #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     x_i,
  input  logic                 start_i,
  input  logic                 boot_i,
  input  logic                 muxes_i,
  input  logic                 wr_root_i,
  input  logic                 wr_square_i,
  input  logic                 root_i,
  output logic [1:0]           N_o,
  output logic [WIDTH/2-1:0]   root_o,
  output logic                 valid_o
);

  localparam int RW = WIDTH / 2;
  localparam int DW = RW + 2;
  localparam int SW = WIDTH + 1;

  localparam logic [SW-1:0] S_INIT = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] D_INIT = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] TWO    = {{(SW-2){1'b0}}, 2'b10};

  logic [WIDTH-1:0] x_r;
  logic [SW-1:0]    s_r;
  logic [DW-1:0]    d_r;
  logic [RW-1:0]    r_r;
  logic             v_r;

  logic [SW-1:0]    a_s;
  logic [SW-1:0]    b_s;
  logic [SW-1:0]    sum_s;
  logic [SW-1:0]    d_ext_s;

  assign d_ext_s = {{(SW-DW){1'b0}}, d_r};

  // Shared adder: D+2 while stepping the increment, S+D while accumulating the square
  always_comb begin
    a_s = d_ext_s;
    b_s = TWO;
    if (muxes_i) begin
      a_s = s_r;
      b_s = d_ext_s;
    end else begin
      a_s = d_ext_s;
      b_s = TWO;
    end
    sum_s = a_s + b_s;
  end

  // Status to the controller; start is passed straight through, the controller registers it
  always_comb begin
    N_o[1] = start_i;
    N_o[0] = (s_r > {1'b0, x_r});
  end

  // Register file: boot overrides every other write; capture samples the pre-edge D
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r <= {WIDTH{1'b0}};
      s_r <= S_INIT;
      d_r <= D_INIT;
      r_r <= {RW{1'b0}};
      v_r <= 1'b0;
    end else if (boot_i) begin
      x_r <= x_i;
      s_r <= S_INIT;
      d_r <= D_INIT;
      v_r <= 1'b0;
    end else begin
      if (wr_root_i) begin
        d_r <= sum_s[DW-1:0];
      end
      if (wr_square_i) begin
        s_r <= sum_s;
      end
      if (root_i) begin
        r_r <= d_r[RW:1];
        v_r <= 1'b1;
      end
    end
  end

  assign root_o  = r_r;
  assign valid_o = v_r;

endmodule

// File: tb/tb_sqrt_datapath.sv
// Self-checking bench for sqrt_datapath: table vectors, hand-written corner sequences
// and random operands compared against a plain-arithmetic integer square root.
module tb_sqrt_datapath;

  logic        clk = 1'b0;
  logic        rst, start, boot, muxes, wr_root, wr_square, root;
  logic [15:0] x;
  logic [1:0]  n;
  logic [7:0]  root_q;
  logic        valid;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sqrt_datapath #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_i        (x),
    .start_i    (start),
    .boot_i     (boot),
    .muxes_i    (muxes),
    .wr_root_i  (wr_root),
    .wr_square_i(wr_square),
    .root_i     (root),
    .N_o        (n),
    .root_o     (root_q),
    .valid_o    (valid)
  );

  typedef struct {
    logic [15:0] x;
    logic [7:0]  r;
  } vec_t;

  vec_t tbl[14];

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock edge with the given controls, then controls return to idle
  task automatic step(input logic b, input logic m, input logic wr, input logic ws, input logic rt);
    boot = b; muxes = m; wr_root = wr; wr_square = ws; root = rt;
    @(posedge clk); #1;
    boot = 1'b0; muxes = 1'b0; wr_root = 1'b0; wr_square = 1'b0; root = 1'b0;
  endtask

  // Plays the ControlPath: boot, iterate until S > X, capture
  task automatic run_sqrt(input logic [15:0] xv, input bit disturb);
    int it = 0;
    x = xv;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    while (n[0] == 1'b0 && it < 300) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (disturb) x = 16'($urandom);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      it++;
    end
    if (n[0] == 1'b0) check("loop_bound", 32'(n[0]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int xr;
    rst = 1'b1; start = 1'b0; boot = 1'b0; muxes = 1'b0;
    wr_root = 1'b0; wr_square = 1'b0; root = 1'b0; x = 16'd0;

    tbl[0]  = '{16'd0,     8'd0};
    tbl[1]  = '{16'd1,     8'd1};
    tbl[2]  = '{16'd2,     8'd1};
    tbl[3]  = '{16'd3,     8'd1};
    tbl[4]  = '{16'd4,     8'd2};
    tbl[5]  = '{16'd15,    8'd3};
    tbl[6]  = '{16'd16,    8'd4};
    tbl[7]  = '{16'd17,    8'd4};
    tbl[8]  = '{16'd99,    8'd9};
    tbl[9]  = '{16'd100,   8'd10};
    tbl[10] = '{16'd255,   8'd15};
    tbl[11] = '{16'd256,   8'd16};
    tbl[12] = '{16'd65024, 8'd254};
    tbl[13] = '{16'd65535, 8'd255};

    // Reset held for two edges with random controls
    for (int i = 0; i < 2; i++) begin
      boot = 1'($urandom); muxes = 1'($urandom); wr_root = 1'($urandom);
      wr_square = 1'($urandom); root = 1'($urandom); x = 16'($urandom);
      @(posedge clk); #1;
    end
    check("rst_root", 32'(root_q), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_n0", 32'(n[0]), 32'd1);
    start = 1'b1; #1;
    check("start_hi", 32'(n[1]), 32'd1);
    start = 1'b0; #1;
    check("start_lo", 32'(n[1]), 32'd0);
    rst = 1'b0;
    boot = 1'b0; muxes = 1'b0; wr_root = 1'b0; wr_square = 1'b0; root = 1'b0;

    // x=0: comparison already true right after boot
    x = 16'd0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("x0_n0", 32'(n[0]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("x0_root", 32'(root_q), 32'd0);
    check("x0_valid", 32'(valid), 32'd1);

    // x=16 step by step
    x = 16'd16;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("x16_s0", 32'(dut.s_r), 32'd1);
    check("x16_d0", 32'(dut.d_r), 32'd1);
    check("x16_valid_boot", 32'(valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("x16_d", 32'(dut.d_r), 32'(2 * k + 1));
      check("x16_n0_mid", 32'(n[0]), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("x16_s", 32'(dut.s_r), 32'((k + 1) * (k + 1)));
      check("x16_n0", 32'(n[0]), ((k + 1) * (k + 1) > 16) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("x16_root", 32'(root_q), 32'd4);

    // x=65535: full iteration, S reaches 2^16 without wrapping
    x = 16'd65535;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int it = 0; it < 300 && n[0] == 1'b0; it++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (dut.s_r == 17'd65025) check("max_n0_at_65025", 32'(n[0]), 32'd0);
    end
    check("max_s", 32'(dut.s_r), 32'd65536);
    check("max_d", 32'(dut.d_r), 32'd511);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("max_root", 32'(root_q), 32'd255);

    // Boot wins over every other write; root kept from previous capture
    x = 16'd9;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("prio_s", 32'(dut.s_r), 32'd1);
    check("prio_d", 32'(dut.d_r), 32'd1);
    check("prio_x", 32'(dut.x_r), 32'd9);
    check("prio_valid", 32'(valid), 32'd0);
    check("prio_root", 32'(root_q), 32'd255);

    // Both writes in one cycle take the same sum S+D = 2
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("both_s", 32'(dut.s_r), 32'd2);
    check("both_d", 32'(dut.d_r), 32'd2);

    // Capture alongside a D write uses the pre-edge D (3 -> root 1)
    x = 16'd16;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("cap_pre_root", 32'(root_q), 32'd1);
    check("cap_pre_d", 32'(dut.d_r), 32'd5);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check("hold_root", 32'(root_q), 32'd1);
      check("hold_valid", 32'(valid), 32'd1);
    end

    // Reset halfway through x=100 discards everything
    x = 16'd100;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("mrst_s", 32'(dut.s_r), 32'd1);
    check("mrst_d", 32'(dut.d_r), 32'd1);
    check("mrst_x", 32'(dut.x_r), 32'd0);
    check("mrst_root", 32'(root_q), 32'd0);
    check("mrst_valid", 32'(valid), 32'd0);
    run_sqrt(16'd100, 1'b0);
    check("rerun_root", 32'(root_q), 32'd10);
    check("rerun_valid", 32'(valid), 32'd1);

    // x_i changed after boot does not affect the result
    run_sqrt(16'd100, 1'b1);
    check("disturb_root", 32'(root_q), 32'd10);

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      run_sqrt(tbl[i].x, 1'b0);
      check("tbl_root", 32'(root_q), 32'(tbl[i].r));
      check("tbl_valid", 32'(valid), 32'd1);
    end

    // Random operands against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      xr = int'($urandom_range(0, 65535));
      run_sqrt(16'(xr), (i % 2) == 1);
      check("rand_root", 32'(root_q), 32'(isqrt(xr)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
